// File: rtl/edge_writer_pkg.sv
// Shared types and constants for the edge pixel writer.
// Pixels are packed little-endian, four per 32-bit word.
package edge_writer_pkg;

  localparam int PIX_PER_WORD = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  typedef struct packed {
    be_t   be;
    word_t data;
  } wr_ent_t;

  localparam int ENT_W = $bits(wr_ent_t);

  // Byte enables covering lanes 0..idx
  function automatic be_t lane_mask(
    input logic [1:0] idx
  );
    be_t m;
    unique case (1'b1)
      (idx == 2'd0): m = 4'b0001;
      (idx == 2'd1): m = 4'b0011;
      (idx == 2'd2): m = 4'b0111;
      default:       m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Small synchronous FIFO for packed write entries.
// A push into a full FIFO succeeds when a pop happens the same cycle.
module sync_word_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/edge_pixel_writer.sv
// Packs the 8-bit edge pixel stream into 32-bit words and
// writes them to frame memory through a valid/ready port.
module edge_pixel_writer
  import edge_writer_pkg::*;
#(
  parameter int                ADDR_W     = 19,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [20:0]       total_pixel,
  input  logic [7:0]        pixel_in,
  input  logic              pixel_valid,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  output logic              busy,
  output logic              wr_done,
  output logic              overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [20:0]       total_q;
  logic [20:0]       pix_cnt;
  logic [1:0]        byte_idx;
  word_t             acc;
  logic [ADDR_W-1:0] addr;

  logic              start_ok;
  logic              accept;
  logic              last_px;
  logic              push;
  logic              pop;
  logic              drop;
  logic              flush_clear;
  word_t             merged;
  wr_ent_t           push_ent;
  wr_ent_t           head;
  logic [ENT_W-1:0]  head_raw;
  logic              f_full;
  logic              f_empty;
  logic [CW-1:0]     f_cnt;

  assign start_ok = start &&
    ((state == ST_IDLE) || (state == ST_DONE));
  assign accept   = (state == ST_RUN) && pixel_valid &&
    (total_q != '0);
  assign last_px  = ((pix_cnt + 21'd1) == total_q);
  assign merged   = acc |
    (32'(pixel_in) << {byte_idx, 3'b000});
  assign push     = accept &&
    ((byte_idx == 2'd3) || last_px);
  assign push_ent = '{be: lane_mask(byte_idx), data: merged};
  assign pop      = !f_empty && mem_ready;
  assign drop     = push && f_full && !pop;
  assign head     = wr_ent_t'(head_raw);

  // FIFO will be empty after this cycle: nothing left to write
  assign flush_clear = f_empty ||
    ((f_cnt == CW'(1)) && pop);

  sync_word_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .dout  (head_raw),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  // Write port driven straight from the FIFO head
  always_comb begin
    mem_wr_en = !f_empty;
    mem_addr  = addr;
    mem_wdata = f_empty ? '0 : head.data;
    mem_be    = f_empty ? '0 : head.be;
    busy      = (state == ST_RUN) || (state == ST_FLUSH);
  end

  // Frame control, pixel packing and address tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      total_q  <= '0;
      pix_cnt  <= '0;
      byte_idx <= '0;
      acc      <= '0;
      addr     <= BASE_ADDR;
      overflow <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      if (pop) addr <= addr + 1'b1;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state    <= ST_RUN;
            total_q  <= total_pixel;
            pix_cnt  <= '0;
            byte_idx <= '0;
            acc      <= '0;
            addr     <= BASE_ADDR;
            overflow <= 1'b0;
            wr_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (total_q == '0) begin
            state   <= ST_DONE;
            wr_done <= 1'b1;
          end else if (accept) begin
            pix_cnt <= pix_cnt + 21'd1;
            if (push) begin
              acc      <= '0;
              byte_idx <= '0;
            end else begin
              acc      <= merged;
              byte_idx <= byte_idx + 2'd1;
            end
            if (drop)    overflow <= 1'b1;
            if (last_px) state    <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_clear) begin
            state   <= ST_DONE;
            wr_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_pixel_writer.sv
// Directed bench for edge_pixel_writer.
// Inputs change on negedge; checks sample on negedge.
module tb_edge_pixel_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [20:0] total_pixel;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        mem_wr_en;
  logic [18:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        busy;
  logic        wr_done;
  logic        overflow;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int last_hs = -1;

  logic [18:0] q_addr [$];
  logic [31:0] q_data [$];
  logic [3:0]  q_be   [$];

  logic        stall_prev = 1'b0;
  logic [18:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;

  always #5 clk = ~clk;

  edge_pixel_writer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .total_pixel (total_pixel),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .wr_done     (wr_done),
    .overflow    (overflow)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h",
        tag, got, exp);
    end
  endtask

  // Record handshakes; check write port holds during stalls
  always @(posedge clk) begin
    cyc++;
    if (stall_prev && !reset) begin
      chk("stall_wr_en", 64'(mem_wr_en), 64'd1);
      chk("stall_addr",  64'(mem_addr),  64'(st_addr));
      chk("stall_data",  64'(mem_wdata), 64'(st_data));
      chk("stall_be",    64'(mem_be),    64'(st_be));
    end
    if (mem_wr_en && mem_ready) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_wdata);
      q_be.push_back(mem_be);
      last_hs = cyc;
    end
    stall_prev = mem_wr_en && !mem_ready;
    st_addr    = mem_addr;
    st_data    = mem_wdata;
    st_be      = mem_be;
  end

  task automatic do_start(input logic [20:0] n);
    @(negedge clk);
    start       = 1'b1;
    total_pixel = n;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic send_px(
    input logic [7:0] first,
    input int         n
  );
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_in    = first + 8'(i);
    end
    @(negedge clk);
    pixel_valid = 1'b0;
  endtask

  task automatic wait_done(
    input string tag,
    input int    budget
  );
    int n = 0;
    while (!wr_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(wr_done), 64'd1);
  endtask

  task automatic chk_word(
    input string       tag,
    input int          idx,
    input logic [18:0] a,
    input logic [31:0] d,
    input logic [3:0]  b
  );
    if (idx < q_data.size()) begin
      chk({tag, "_addr"}, 64'(q_addr[idx]), 64'(a));
      chk({tag, "_data"}, 64'(q_data[idx]), 64'(d));
      chk({tag, "_be"},   64'(q_be[idx]),   64'(b));
    end else begin
      chk({tag, "_present"}, 64'(q_data.size()),
        64'(idx + 1));
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
    chk({tag, "_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_be"},    64'(mem_be),    64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_done"},  64'(wr_done),   64'd0);
    chk({tag, "_ovf"},   64'(overflow),  64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    total_pixel = '0;
    pixel_in    = '0;
    pixel_valid = 1'b0;
    mem_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_idle_outs("rst");
    reset = 1'b0;

    // Two full words, back-to-back pixels
    q_addr.delete(); q_data.delete(); q_be.delete();
    do_start(21'd8);
    chk("t1_busy", 64'(busy), 64'd1);
    send_px(8'h01, 8);
    wait_done("t1_done", 40);
    chk("t1_done_lat", 64'(cyc - last_hs), 64'd0);
    chk("t1_nwords", 64'(q_data.size()), 64'd2);
    chk_word("t1_w0", 0, 19'd0, 32'h04030201, 4'hF);
    chk_word("t1_w1", 1, 19'd1, 32'h08070605, 4'hF);
    chk("t1_ovf", 64'(overflow), 64'd0);

    // Partial final word
    q_addr.delete(); q_data.delete(); q_be.delete();
    do_start(21'd6);
    send_px(8'hA0, 6);
    wait_done("t2_done", 40);
    chk("t2_nwords", 64'(q_data.size()), 64'd2);
    chk_word("t2_w0", 0, 19'd0, 32'hA3A2A1A0, 4'hF);
    chk_word("t2_w1", 1, 19'd1, 32'h0000A5A4, 4'b0011);

    // Memory stalled through the whole frame: overflow
    q_addr.delete(); q_data.delete(); q_be.delete();
    mem_ready = 1'b0;
    do_start(21'd32);
    send_px(8'h00, 32);
    repeat (2) @(negedge clk);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_wr_en", 64'(mem_wr_en), 64'd1);
    chk("t3_nodone", 64'(wr_done), 64'd0);
    chk("t3_nowrite", 64'(q_data.size()), 64'd0);
    mem_ready = 1'b1;
    wait_done("t3_done", 40);
    chk("t3_nwords", 64'(q_data.size()), 64'd4);
    chk_word("t3_w0", 0, 19'd0, 32'h03020100, 4'hF);
    chk_word("t3_w1", 1, 19'd1, 32'h07060504, 4'hF);
    chk_word("t3_w2", 2, 19'd2, 32'h0B0A0908, 4'hF);
    chk_word("t3_w3", 3, 19'd3, 32'h0F0E0D0C, 4'hF);
    chk("t3_ovf_hold", 64'(overflow), 64'd1);

    // Toggling ready with writes in flight
    q_addr.delete(); q_data.delete(); q_be.delete();
    do_start(21'd16);
    chk("t4_ovf_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_in    = 8'h10 + 8'(i);
      mem_ready   = i[0];
    end
    for (int i = 0; i < 40 && !wr_done; i++) begin
      @(negedge clk);
      pixel_valid = 1'b0;
      mem_ready   = ~mem_ready;
    end
    mem_ready = 1'b1;
    chk("t4_done", 64'(wr_done), 64'd1);
    chk("t4_ovf", 64'(overflow), 64'd0);
    chk("t4_nwords", 64'(q_data.size()), 64'd4);
    chk_word("t4_w0", 0, 19'd0, 32'h13121110, 4'hF);
    chk_word("t4_w1", 1, 19'd1, 32'h17161514, 4'hF);
    chk_word("t4_w2", 2, 19'd2, 32'h1B1A1918, 4'hF);
    chk_word("t4_w3", 3, 19'd3, 32'h1F1E1D1C, 4'hF);

    // Reset mid-frame, then a fresh one-word frame
    do_start(21'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_in    = 8'h40 + 8'(i);
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    chk_idle_outs("t5_rst");
    reset = 1'b0;
    q_addr.delete(); q_data.delete(); q_be.delete();
    do_start(21'd4);
    send_px(8'h51, 4);
    wait_done("t5_done", 40);
    chk("t5_nwords", 64'(q_data.size()), 64'd1);
    chk_word("t5_w0", 0, 19'd0, 32'h54535251, 4'hF);

    // Empty frame; start while busy is ignored
    q_addr.delete(); q_data.delete(); q_be.delete();
    @(negedge clk);
    start       = 1'b1;
    total_pixel = 21'd0;
    @(negedge clk);
    total_pixel = 21'd5;
    chk("t6_busy", 64'(busy), 64'd1);
    chk("t6_done_lo", 64'(wr_done), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("t6_done_hi", 64'(wr_done), 64'd1);
    chk("t6_idle", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    chk("t6_done_hold", 64'(wr_done), 64'd1);
    chk("t6_busy_hold", 64'(busy), 64'd0);
    chk("t6_nowrite", 64'(q_data.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, errs);
    $finish;
  end

endmodule
